// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG health reader.
package trng_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned LANES    = WORD_W / SAMPLE_W;
  localparam int unsigned PACK_W   = WORD_W - SAMPLE_W;
  localparam int unsigned DROP_W   = 8;

  localparam logic [1:0] ALARM_RCT = 2'b01;
  localparam logic [1:0] ALARM_APT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STARTUP = 2'd1,
    ST_RUN     = 2'd2,
    ST_ALARM   = 2'd3
  } trng_state_e;

endpackage

// File: rtl/trng_health_test.sv
// Online health tests for the TRNG byte stream: repetition count (RCT) and,
// when TRNG_HEALTH_APT_EN is defined, adaptive proportion (APT).
// Fail outputs are combinational on the incoming sample.
module trng_health_test
  import trng_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = 4
`ifdef TRNG_HEALTH_APT_EN
  ,
  parameter int unsigned APT_WINDOW = 512,
  parameter int unsigned APT_CUTOFF = 13
`endif
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                valid,
  input  logic                restart,
  output logic                rct_fail,
  output logic                apt_fail
);

  localparam int unsigned RCT_W = $clog2(RCT_CUTOFF + 1);

  logic [SAMPLE_W-1:0] rct_last;
  logic [RCT_W-1:0]    rct_cnt;
  logic [RCT_W-1:0]    rct_cnt_nxt;
  logic                rct_empty;

  // Run length including the incoming sample; restart makes it a first sample.
  always_comb begin
    rct_cnt_nxt = RCT_W'(1);
    if (!restart && !rct_empty && (sample == rct_last)) begin
      rct_cnt_nxt = (rct_cnt >= RCT_W'(RCT_CUTOFF)) ? rct_cnt : rct_cnt + RCT_W'(1);
    end
  end

  assign rct_fail = valid && (rct_cnt_nxt >= RCT_W'(RCT_CUTOFF));

  // RCT history register.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      rct_last  <= '0;
      rct_cnt   <= '0;
      rct_empty <= 1'b1;
    end else if (valid) begin
      rct_last  <= sample;
      rct_cnt   <= rct_cnt_nxt;
      rct_empty <= 1'b0;
    end else if (restart) begin
      rct_cnt   <= '0;
      rct_empty <= 1'b1;
    end
  end

`ifdef TRNG_HEALTH_APT_EN
  localparam int unsigned APT_W = $clog2(APT_WINDOW + 1);

  logic [SAMPLE_W-1:0] apt_ref;
  logic [APT_W-1:0]    apt_cnt;
  logic [APT_W-1:0]    apt_cnt_nxt;
  logic [APT_W-1:0]    win_cnt;
  logic [APT_W-1:0]    win_nxt;
  logic                win_start;

  // A window begins on restart or once the previous window has wrapped.
  assign win_start = restart || (win_cnt == '0);

  // Reference-match count and window position including the incoming sample.
  always_comb begin
    apt_cnt_nxt = APT_W'(1);
    win_nxt     = APT_W'(1);
    if (!win_start) begin
      win_nxt     = win_cnt + APT_W'(1);
      apt_cnt_nxt = apt_cnt;
      if ((sample == apt_ref) && (apt_cnt < APT_W'(APT_CUTOFF))) begin
        apt_cnt_nxt = apt_cnt + APT_W'(1);
      end
    end
    if (win_nxt == APT_W'(APT_WINDOW)) begin
      win_nxt = '0;
    end
  end

  assign apt_fail = valid && (apt_cnt_nxt >= APT_W'(APT_CUTOFF));

  // APT window state.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      apt_ref <= '0;
      apt_cnt <= '0;
      win_cnt <= '0;
    end else if (valid) begin
      if (win_start) begin
        apt_ref <= sample;
      end
      apt_cnt <= apt_cnt_nxt;
      win_cnt <= win_nxt;
    end else if (restart) begin
      apt_cnt <= '0;
      win_cnt <= '0;
    end
  end
`else
  assign apt_fail = 1'b0;
`endif

endmodule

// File: rtl/trng_health_reader.sv
// TRNG consumer: health-tests every sample, discards a startup window, packs
// healthy bytes into 32-bit words behind a valid/ready buffer, and latches a
// sticky alarm on any test failure. Optional APT: define TRNG_HEALTH_APT_EN.
module trng_health_reader
  import trng_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = 4,
  parameter int unsigned APT_WINDOW = 512,
  parameter int unsigned APT_CUTOFF = 13
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic [WORD_W-1:0]   word_out,
  output logic                word_valid,
  input  logic                word_ready,
  output logic                alarm,
  output logic [1:0]          alarm_code,
  input  logic                clear_alarm,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam logic [1:0] IDLE    = 2'(ST_IDLE);
  localparam logic [1:0] STARTUP = 2'(ST_STARTUP);
  localparam logic [1:0] RUN     = 2'(ST_RUN);
  localparam logic [1:0] ALARM   = 2'(ST_ALARM);

  localparam int unsigned SU_W   = $clog2(APT_WINDOW + 1);
  localparam int unsigned LANE_W = $clog2(LANES);

  // Reject configurations the counters cannot represent.
  if ((RCT_CUTOFF < 1) || (APT_CUTOFF < 1) || (APT_CUTOFF > APT_WINDOW) || (APT_WINDOW < 2)) begin : g_bad_cfg
    $error("trng_health_reader: invalid RCT_CUTOFF/APT_CUTOFF/APT_WINDOW");
  end

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [SU_W-1:0]   su_cnt;
  logic [LANE_W-1:0] lane;
  logic [PACK_W-1:0] pack;

  logic take_clear;
  logic test_valid;
  logic test_restart;
  logic rct_fail;
  logic apt_fail;
  logic fail;
  logic run_take;
  logic word_done;
  logic load;
  logic drop;
  logic [WORD_W-1:0] word_nxt;

  // A clear in ALARM wins over any failure and its sample starts STARTUP.
  assign take_clear   = (state == ALARM) && clear_alarm;
  assign test_valid   = sample_valid &&
                        (take_clear || (enable && ((state == STARTUP) || (state == RUN))));
  assign test_restart = take_clear || (state == IDLE);
  assign fail         = test_valid && !take_clear && (rct_fail || apt_fail);
  assign run_take     = test_valid && !fail && (state == RUN);
  assign word_done    = run_take && (lane == LANE_W'(LANES - 1));
  assign load         = word_done && (!word_valid || word_ready);
  assign drop         = word_done && !load;
  assign word_nxt     = {sample_in, pack};

  trng_health_test #(
    .RCT_CUTOFF(RCT_CUTOFF)
`ifdef TRNG_HEALTH_APT_EN
    ,
    .APT_WINDOW(APT_WINDOW),
    .APT_CUTOFF(APT_CUTOFF)
`endif
  ) u_test (
    .clk      (clk),
    .n_reset  (n_reset),
    .sample   (sample_in),
    .valid    (test_valid),
    .restart  (test_restart),
    .rct_fail (rct_fail),
    .apt_fail (apt_fail)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable) state_nxt = STARTUP;
      end
      STARTUP: begin
        if (!enable)                                          state_nxt = IDLE;
        else if (fail)                                        state_nxt = ALARM;
        else if (test_valid && (su_cnt == SU_W'(APT_WINDOW - 1))) state_nxt = RUN;
      end
      RUN: begin
        if (!enable)   state_nxt = IDLE;
        else if (fail) state_nxt = ALARM;
      end
      ALARM: begin
        if (clear_alarm) state_nxt = STARTUP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Startup discard counter; restarts from the clearing sample after an alarm.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      su_cnt <= '0;
    end else if (take_clear) begin
      su_cnt <= test_valid ? SU_W'(1) : '0;
    end else if ((state != STARTUP) || !enable) begin
      su_cnt <= '0;
    end else if (test_valid && !fail) begin
      su_cnt <= su_cnt + SU_W'(1);
    end
  end

  // Sticky alarm with OR-accumulated failure code.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      alarm      <= 1'b0;
      alarm_code <= 2'b00;
    end else if (take_clear) begin
      alarm      <= 1'b0;
      alarm_code <= 2'b00;
    end else if (fail) begin
      alarm      <= 1'b1;
      alarm_code <= alarm_code | (rct_fail ? ALARM_RCT : 2'b00) | (apt_fail ? ALARM_APT : 2'b00);
    end
  end

  // Byte packer for lanes 0..2; lane 3 comes straight from the input.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      lane <= '0;
      pack <= '0;
    end else if ((state != RUN) || !enable || fail) begin
      lane <= '0;
      pack <= '0;
    end else if (run_take) begin
      if (word_done) begin
        lane <= '0;
      end else begin
        lane <= lane + LANE_W'(1);
        for (int i = 0; i < int'(LANES) - 1; i++) begin
          if (lane == LANE_W'(i)) pack[i*SAMPLE_W +: SAMPLE_W] <= sample_in;
        end
      end
    end
  end

  // Output buffer; a failure flushes it even mid-handshake.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (fail) begin
      word_valid <= 1'b0;
    end else if (load) begin
      word_out   <= word_nxt;
      word_valid <= 1'b1;
    end else if (word_valid && word_ready) begin
      word_valid <= 1'b0;
    end
  end

  // Saturating count of words lost to a full output buffer.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_trng_health_reader.sv
// Directed bench for trng_health_reader: vector table for packing, RCT alarm
// and clear, plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_trng_health_reader;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  sample_in = 8'h00;
  logic        sample_valid = 1'b0;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        alarm;
  logic [1:0]  alarm_code;
  logic        clear_alarm = 1'b0;
  logic [7:0]  drop_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int bad_xfer = 0;
  logic [31:0] last_xfer = 32'h0;

  always #5 clk = ~clk;

  trng_health_reader dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .alarm        (alarm),
    .alarm_code   (alarm_code),
    .clear_alarm  (clear_alarm),
    .drop_cnt     (drop_cnt)
  );

  // Record transfers one half-cycle before the edge that completes them.
  always @(negedge clk) begin
    if (n_reset && word_valid && word_ready) begin
      last_xfer = word_out;
      for (int b = 0; b < 4; b++) begin
        if (word_out[b*8 +: 8] == 8'h5A) bad_xfer++;
      end
    end
  end

  typedef struct {
    logic        v;
    logic [7:0]  s;
    logic        rdy;
    logic        clr;
    logic        e_valid;
    logic [31:0] e_word;
    logic        e_alarm;
    logic [1:0]  e_code;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    sample_in    = b;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  // Feed n counting samples and report how many cycles showed word_valid.
  task automatic fill(input int n, output int vhigh);
    vhigh = 0;
    for (int i = 0; i < n; i++) begin
      put(8'(i));
      if (word_valid) vhigh++;
    end
  endtask

  initial begin
    int vh;

    tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00};
    tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00};
    tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 2'b00};
    tbl[3]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 32'h44332211, 1'b0, 2'b00};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h44332211, 1'b0, 2'b00};
    tbl[5]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 32'h44332211, 1'b0, 2'b00};
    tbl[6]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 32'h44332211, 1'b0, 2'b00};
    tbl[7]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 32'h44332211, 1'b0, 2'b00};
    tbl[8]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 2'b01};
    tbl[9]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 2'b01};
    tbl[10] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 2'b01};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 2'b00};

    // Reset values
    step();
    step();
    chk("rst.word_out",   word_out,   32'h0);
    chk("rst.word_valid", word_valid, 32'h0);
    chk("rst.alarm",      alarm,      32'h0);
    chk("rst.alarm_code", alarm_code, 32'h0);
    chk("rst.drop_cnt",   drop_cnt,   32'h0);

    // Startup: 512 samples discarded
    n_reset    = 1'b1;
    enable     = 1'b1;
    word_ready = 1'b1;
    step();
    fill(512, vh);
    chk("startup.no_word", vh, 32'd0);
    chk("startup.alarm",   alarm, 32'h0);

    // Packing, held word, RCT alarm with flush, ALARM ignores, clear
    for (int i = 0; i < 12; i++) begin
      sample_in    = tbl[i].s;
      sample_valid = tbl[i].v;
      word_ready   = tbl[i].rdy;
      clear_alarm  = tbl[i].clr;
      step();
      sample_valid = 1'b0;
      clear_alarm  = 1'b0;
      chk($sformatf("vec%0d.word_valid", i), word_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d.alarm", i),      alarm,      tbl[i].e_alarm);
      chk($sformatf("vec%0d.alarm_code", i), alarm_code, tbl[i].e_code);
      if (tbl[i].e_valid) chk($sformatf("vec%0d.word_out", i), word_out, tbl[i].e_word);
    end

    // Recovery: a full startup again before the next word
    word_ready = 1'b1;
    fill(512, vh);
    put(8'hA1);
    put(8'hA2);
    put(8'hA3);
    if (word_valid) vh++;
    chk("recover.no_early_word", vh, 32'd0);
    put(8'hA4);
    chk("recover.word_valid", word_valid, 32'h1);
    chk("recover.word_out",   word_out,   32'hA4A3A2A1);
    step();
    chk("recover.xfer",       last_xfer,  32'hA4A3A2A1);
    chk("recover.consumed",   word_valid, 32'h0);

    // Backpressure: first word held, second dropped
    word_ready = 1'b0;
    put(8'hB1); put(8'hB2); put(8'hB3); put(8'hB4);
    chk("bp.first_valid", word_valid, 32'h1);
    chk("bp.first_word",  word_out,   32'hB4B3B2B1);
    put(8'hB5); put(8'hB6); put(8'hB7); put(8'hB8);
    chk("bp.held_word",   word_out,   32'hB4B3B2B1);
    chk("bp.held_valid",  word_valid, 32'h1);
    chk("bp.drop_cnt",    drop_cnt,   32'd1);
    word_ready = 1'b1;
    step();
    chk("bp.xfer",        last_xfer,  32'hB4B3B2B1);
    chk("bp.after_xfer",  word_valid, 32'h0);

    // Reset with a pending word and a partial packer
    word_ready = 1'b0;
    put(8'hC1); put(8'hC2); put(8'hC3); put(8'hC4);
    chk("rstmid.pending", word_valid, 32'h1);
    put(8'hC5); put(8'hC6);
    n_reset = 1'b0;
    step();
    chk("rstmid.word_out",   word_out,   32'h0);
    chk("rstmid.word_valid", word_valid, 32'h0);
    chk("rstmid.alarm",      alarm,      32'h0);
    chk("rstmid.alarm_code", alarm_code, 32'h0);
    chk("rstmid.drop_cnt",   drop_cnt,   32'h0);
    n_reset    = 1'b1;
    word_ready = 1'b1;
    step();
    fill(512, vh);
    put(8'hD1); put(8'hD2); put(8'hD3);
    if (word_valid) vh++;
    chk("rstmid.no_early_word", vh, 32'd0);
    put(8'hD4);
    chk("rstmid.word_out_after", word_out, 32'hD4D3D2D1);
    step();

    // APT: reference 0x00 recurs non-consecutively
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    for (int i = 0; i < 24; i++) begin
      put(((i % 2) == 0) ? 8'h00 : 8'(8'h10 + i));
    end
    chk("apt.before_cutoff", alarm, 32'h0);
    put(8'h00);
`ifdef TRNG_HEALTH_APT_EN
    chk("apt.alarm",      alarm,      32'h1);
    chk("apt.alarm_code", alarm_code, 32'h2);
`else
    chk("apt.alarm",      alarm,      32'h0);
    chk("apt.alarm_code", alarm_code, 32'h0);
`endif

    chk("rct.no_5a_output", bad_xfer, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/trng_health_reader.md
# trng_health_reader

Consumer-side block for the free-running 8-bit TRNG byte stream. Accepts one sample per `sample_valid` cycle and runs online health tests on every sample: a repetition-count test (RCT) and an adaptive-proportion test (APT). Healthy samples are packed four at a time into 32-bit words for the downstream bus over a valid/ready handshake. A test failure raises a sticky alarm and blocks output until software clears it.

## Interface
Parameters:
- `RCT_CUTOFF`, default 4: number of consecutive identical samples that fails the RCT.
- `APT_WINDOW`, default 512: APT window length in samples; also the startup discard length.
- `APT_CUTOFF`, default 13: number of occurrences of the window reference value that fails the APT.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock.
- `n_reset`, in, 1: reset; synchronous, active-low.
- `enable`, in, 1: level; while low the block idles.
- `sample_in`, in, 8: TRNG byte.
- `sample_valid`, in, 1: `sample_in` is valid this cycle. No backpressure to the source.
- `word_out`, out, 32: packed word, first sample in [7:0].
- `word_valid`, out, 1: `word_out` holds an unconsumed word.
- `word_ready`, in, 1: consumer accepts the word.
- `alarm`, out, 1: sticky health-test failure.
- `alarm_code`, out, 2: bit0 = RCT failed, bit1 = APT failed.
- `clear_alarm`, in, 1: single-cycle pulse that clears the alarm.
- `drop_cnt`, out, 8: saturating count of words lost to backpressure.

## Operation
- States:
  - **IDLE**: reset state.
  - **STARTUP**: samples are tested but discarded.
  - **RUN**: samples are tested and packed.
  - **ALARM**: samples are ignored.
- State transitions:
  - IDLE → STARTUP when `enable`=1.
  - STARTUP → RUN after `APT_WINDOW` accepted samples with no failure.
  - STARTUP or RUN → ALARM on any test failure.
  - ALARM → STARTUP on `clear_alarm`. ALARM is exited only by `clear_alarm` or reset.
  - Any state except ALARM → IDLE when `enable`=0.
- Accepted sample: `sample_valid`=1 in STARTUP or RUN.
- RCT:
  - Holds the last sample and a run count.
  - A sample equal to the last increments the count; any other sample reloads the count to 1.
  - The first sample after entering STARTUP loads the count to 1.
  - Fails when the count reaches `RCT_CUTOFF`.
- APT:
  - The first sample of each window is the reference, with count = 1.
  - Each later sample equal to the reference increments the count.
  - The window counter wraps after `APT_WINDOW` samples; the next sample starts a new window.
  - Fails when the count reaches `APT_CUTOFF`.
  - Counter width is clog2(`APT_WINDOW`+1).
- On failure:
  - `alarm` is set and `alarm_code` is OR-accumulated; simultaneous failures give code 11.
  - Packer is cleared.
  - Output buffer is flushed: `word_valid` drops even mid-handshake (security over protocol).
  - The failing sample is never output.
- `clear_alarm`: zeroes `alarm` and `alarm_code`, and resets RCT/APT state, packer and startup counter.
- Packer:
  - In RUN, samples fill byte lanes 0..3.
  - On the 4th sample the word loads into the output buffer if the buffer is empty or is being consumed this cycle.
  - Otherwise the word is discarded and `drop_cnt` increments, saturating at 255.
  - Packer restarts at lane 0 either way.
- Handshake: transfer occurs when `word_valid` && `word_ready`. `word_out` and `word_valid` are stable until transfer, except on ALARM flush.
- `enable` falling: packer and test state cleared; a pending output word is retained until consumed.

## Timing
- Reset values: `word_out`=0, `word_valid`=0, `alarm`=0, `alarm_code`=00, `drop_cnt`=0, state IDLE.
- Tests evaluate the incoming sample combinationally; `alarm` is high from the edge after the failing sample's edge.
- `word_valid` rises at the edge after the 4th sample's edge (1-cycle latency).
- First output word contains samples `APT_WINDOW`+1 .. `APT_WINDOW`+4 after `enable`.
- `clear_alarm` and a failing sample in the same cycle: clear wins; that sample becomes the first STARTUP sample.

## Configuration
- Macro: `TRNG_HEALTH_APT_EN`.
- Defined: APT is implemented as described.
- Undefined:
  - APT logic is absent and `alarm_code[1]` is constant 0.
  - STARTUP still discards `APT_WINDOW` samples.
  - RCT is always present.

## Structure
- Shared package `trng_pkg` holds:
  - the state enum;
  - alarm code constants `ALARM_RCT`=2'b01 and `ALARM_APT`=2'b10;
  - `SAMPLE_W`=8 and `WORD_W`=32.
- Sub-module `trng_health_test` contains the RCT and APT:
  - inputs: sample, valid, restart;
  - outputs: `rct_fail`, `apt_fail`.
- The top level holds the FSM, packer, output buffer and drop counter.

## Test plan
- **Startup and packing.** Reset, `enable`=1, feed 512 samples 0x00..0xFF twice, then 0x11, 0x22, 0x33, 0x44 with `word_ready`=1 → `word_valid` stays 0 during startup, then `word_out`=0x44332211 one cycle after 0x44.
- **RCT failure.** Default params, in RUN, feed 0x5A four consecutive times → `alarm`=1 and `alarm_code`=01 the cycle after the 4th sample; `word_valid`=0; no word containing 0x5A is ever output.
- **APT failure.** Feed a window whose first sample is 0x00, with 0x00 repeated 12 more times non-consecutively among distinct values → `alarm_code`=10 on the 13th occurrence. With `TRNG_HEALTH_APT_EN` undefined → no alarm.
- **Backpressure.** `word_ready`=0, 8 samples in RUN → first word held unchanged, second dropped, `drop_cnt`=1. Then `word_ready`=1 → first word transfers.
- **Recovery.** Pulse `clear_alarm` in ALARM → state STARTUP, `alarm`=0, `alarm_code`=00; next word appears only after 512+4 samples.
- **Reset mid-operation.** Assert `n_reset`=0 with `word_valid`=1 and a partial packer → all outputs at reset values next cycle; after reset release, nothing is output until a full startup completes.
